// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dsp_pkg                                                         |
// | Purpose  : Shared timing constants for the 640x480@60 text display (80x30). |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dsp_pkg;

    localparam int H_VIS = 640;
    localparam int H_FP  = 16;
    localparam int H_SW  = 96;
    localparam int H_BP  = 48;
    localparam int V_VIS = 480;
    localparam int V_FP  = 10;
    localparam int V_SW  = 2;
    localparam int V_BP  = 33;

    localparam int H_TOTAL      = H_VIS + H_FP + H_SW + H_BP;   // 800
    localparam int V_TOTAL      = V_VIS + V_FP + V_SW + V_BP;   // 525
    localparam int H_SYNC_START = H_VIS + H_FP;                 // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SW - 1;      // 751
    localparam int V_SYNC_START = V_VIS + V_FP;                 // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SW - 1;      // 491

    localparam int CELL_W = 8;
    localparam int CELL_H = 16;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;

    localparam int CNT_W    = 10;
    localparam int FCNT_W   = 5;
    localparam int TXTROW_W = 5;
    localparam int TXTCOL_W = 7;
    localparam int CHRROW_W = 4;
    localparam int CHRCOL_W = 3;

endpackage
`default_nettype wire

// File: rtl/dsp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dsp_if                                                          |
// | Purpose  : Timing bundle from the generator to the display memory refresh. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dsp_if;
    import dsp_pkg::*;

    logic                pixclk;
    logic [TXTROW_W-1:0] txtrow;
    logic [TXTCOL_W-1:0] txtcol;
    logic [CHRROW_W-1:0] chrrow;
    logic [CHRCOL_W-1:0] chrcol;
    logic                blank;
    logic                hsync;
    logic                vsync;
    logic                blink;

    modport master (
        output pixclk, txtrow, txtcol, chrrow, chrcol, blank, hsync, vsync, blink
    );

    modport slave (
        input  pixclk, txtrow, txtcol, chrrow, chrcol, blank, hsync, vsync, blink
    );

endinterface
`default_nettype wire

// File: rtl/dsp_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dsp_axis                                                        |
// | Purpose  : One display axis counter with blank/sync decode of the next     |
// |            count, so the caller can register its outputs in step.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dsp_axis
    import dsp_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_adv,
    output logic      [CNT_W-1:0] o_next_count,
    output logic                  o_next_blank,
    output logic                  o_next_sync,
    output logic                  o_wrap
);

    localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam int SYNC_START = VISIBLE + FRONT;
    localparam int SYNC_END   = SYNC_START + SYNC - 1;

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_wrap;

    always_comb begin
        w_wrap      = i_adv && (r_count == CNT_W'(TOTAL - 1));
        w_count_nxt = r_count;
        if (w_wrap) begin
            w_count_nxt = '0;
        end else if (i_adv) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Sync is active low across the inclusive [SYNC_START, SYNC_END] window.
    assign o_next_count = w_count_nxt;
    assign o_next_blank = (w_count_nxt >= CNT_W'(VISIBLE));
    assign o_next_sync  = !((w_count_nxt >= CNT_W'(SYNC_START)) &&
                            (w_count_nxt <= CNT_W'(SYNC_END)));
    assign o_wrap       = w_wrap;

endmodule
`default_nettype wire

// File: rtl/dsp_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dsp_timing                                                      |
// | Purpose  : Text-mode display timing generator (80x30 cells, 8x16 font).    |
// |            Optional macro DSP_BLINK_EN enables the frame counter / blink.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dsp_timing #(
    parameter int H_VIS = dsp_pkg::H_VIS,
    parameter int H_FP  = dsp_pkg::H_FP,
    parameter int H_SW  = dsp_pkg::H_SW,
    parameter int H_BP  = dsp_pkg::H_BP,
    parameter int V_VIS = dsp_pkg::V_VIS,
    parameter int V_FP  = dsp_pkg::V_FP,
    parameter int V_SW  = dsp_pkg::V_SW,
    parameter int V_BP  = dsp_pkg::V_BP
) (
    input  wire logic clk,
    input  wire logic rst,
    dsp_if.master     disp
);
    import dsp_pkg::*;

    logic                r_pixclk;
    logic [CNT_W-1:0]    w_hnext;
    logic [CNT_W-1:0]    w_vnext;
    logic                w_hblank;
    logic                w_vblank;
    logic                w_hsync;
    logic                w_vsync;
    logic                w_hwrap;
    logic                w_vwrap;
    logic                w_blank_nxt;
    logic                w_blink_nxt;
    logic                w_unused_ok;

    logic [TXTROW_W-1:0] r_txtrow;
    logic [TXTCOL_W-1:0] r_txtcol;
    logic [CHRROW_W-1:0] r_chrrow;
    logic [CHRCOL_W-1:0] r_chrcol;
    logic                r_blank;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixclk <= 1'b0;
        end else begin
            r_pixclk <= ~r_pixclk;
        end
    end

    dsp_axis #(
        .VISIBLE (H_VIS),
        .FRONT   (H_FP),
        .SYNC    (H_SW),
        .BACK    (H_BP)
    ) u_haxis (
        .clk          (clk),
        .rst          (rst),
        .i_adv        (r_pixclk),
        .o_next_count (w_hnext),
        .o_next_blank (w_hblank),
        .o_next_sync  (w_hsync),
        .o_wrap       (w_hwrap)
    );

    dsp_axis #(
        .VISIBLE (V_VIS),
        .FRONT   (V_FP),
        .SYNC    (V_SW),
        .BACK    (V_BP)
    ) u_vaxis (
        .clk          (clk),
        .rst          (rst),
        .i_adv        (w_hwrap),
        .o_next_count (w_vnext),
        .o_next_blank (w_vblank),
        .o_next_sync  (w_vsync),
        .o_wrap       (w_vwrap)
    );

`ifdef DSP_BLINK_EN
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;

    assign w_fcnt_nxt  = r_fcnt + FCNT_W'(w_vwrap);
    assign w_blink_nxt = w_fcnt_nxt[FCNT_W-1];
    assign w_unused_ok = w_vnext[CNT_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= w_fcnt_nxt;
        end
    end
`else
    assign w_blink_nxt = 1'b0;
    assign w_unused_ok = w_vnext[CNT_W-1] ^ w_vwrap;
`endif

    assign w_blank_nxt = w_hblank | w_vblank;

    // Outputs are registered from the next counts so they move in step with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txtrow <= '0;
            r_txtcol <= '0;
            r_chrrow <= '0;
            r_chrcol <= '0;
            r_blank  <= 1'b0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_blink  <= 1'b0;
        end else begin
            r_txtcol <= w_blank_nxt ? '0 : w_hnext[9:3];
            r_chrcol <= w_blank_nxt ? '0 : w_hnext[2:0];
            r_txtrow <= w_blank_nxt ? '0 : w_vnext[8:4];
            r_chrrow <= w_blank_nxt ? '0 : w_vnext[3:0];
            r_blank  <= w_blank_nxt;
            r_hsync  <= w_hsync;
            r_vsync  <= w_vsync;
            r_blink  <= w_blink_nxt;
        end
    end

    assign disp.pixclk = r_pixclk;
    assign disp.txtrow = r_txtrow;
    assign disp.txtcol = r_txtcol;
    assign disp.chrrow = r_chrrow;
    assign disp.chrcol = r_chrcol;
    assign disp.blank  = r_blank;
    assign disp.hsync  = r_hsync;
    assign disp.vsync  = r_vsync;
    assign disp.blink  = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_dsp_timing.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dsp_timing                                                   |
// | Purpose  : Scoreboard bench: full-size instance for line timing, reduced   |
// |            instance for frame wrap, vsync and blink (DSP_BLINK_EN aware).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dsp_timing;

    // Full-size timing (F) and a reduced frame (S) so many frames fit the run.
    localparam int F_HV = 640, F_HF = 16, F_HS = 96, F_HB = 48;
    localparam int F_VV = 480, F_VF = 10, F_VS = 2,  F_VB = 33;
    localparam int S_HV = 16,  S_HF = 2,  S_HS = 3,  S_HB = 3;
    localparam int S_VV = 32,  S_VF = 2,  S_VS = 2,  S_VB = 2;
`ifdef DSP_BLINK_EN
    localparam int BK = 1;
`else
    localparam int BK = 0;
`endif

    typedef struct {
        int         h, v, f;
        logic [4:0] txtrow;
        logic [6:0] txtcol;
        logic [3:0] chrrow;
        logic [2:0] chrcol;
        logic       blank, hsync, vsync, blink;
    } exp_t;

    typedef struct {
        int d, h, v, f;
        int row, col, crow, ccol, bl, hs, vs, bk;
        bit hit;
    } hand_t;

    logic clk = 1'b0;
    logic rst_f = 1'b1;
    logic rst_s = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done_f = 0;
    bit   done_s = 0;
    exp_t  q_f[$];
    exp_t  q_s[$];
    hand_t hand[$];

    always #10 clk = ~clk;

    dsp_if if_f();
    dsp_if if_s();

    dsp_timing dut_f (
        .clk  (clk),
        .rst  (rst_f),
        .disp (if_f)
    );

    dsp_timing #(
        .H_VIS (S_HV), .H_FP (S_HF), .H_SW (S_HS), .H_BP (S_HB),
        .V_VIS (S_VV), .V_FP (S_VF), .V_SW (S_VS), .V_BP (S_VB)
    ) dut_s (
        .clk  (clk),
        .rst  (rst_s),
        .disp (if_s)
    );

    function automatic void chk(string tag, string nm, int h, int v,
                                logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s %s at (%0d,%0d): got %0d, expected %0d", tag, nm, h, v, act, req);
        end
    endfunction

    function automatic exp_t mk(int h, int v, int f, int hv, int hf, int hs,
                                int vv, int vf, int vs);
        exp_t e;
        logic bl;
        bl       = (h >= hv) || (v >= vv);
        e.h      = h;
        e.v      = v;
        e.f      = f;
        e.blank  = bl;
        e.txtcol = bl ? 7'd0 : 7'(h / 8);
        e.chrcol = bl ? 3'd0 : 3'(h % 8);
        e.txtrow = bl ? 5'd0 : 5'(v / 16);
        e.chrrow = bl ? 4'd0 : 4'(v % 16);
        e.hsync  = !((h >= hv + hf) && (h < hv + hf + hs));
        e.vsync  = !((v >= vv + vf) && (v < vv + vf + vs));
        e.blink  = (BK == 1) ? (((f / 16) % 2) == 1) : 1'b0;
        return e;
    endfunction

    task automatic push_seg(input int d, input int npix);
        int h, v, f, ht, vt;
        h = 0; v = 0; f = 0;
        ht = (d == 0) ? (F_HV + F_HF + F_HS + F_HB) : (S_HV + S_HF + S_HS + S_HB);
        vt = (d == 0) ? (F_VV + F_VF + F_VS + F_VB) : (S_VV + S_VF + S_VS + S_VB);
        for (int i = 0; i < npix; i++) begin
            if (d == 0) q_f.push_back(mk(h, v, f, F_HV, F_HF, F_HS, F_VV, F_VF, F_VS));
            else        q_s.push_back(mk(h, v, f, S_HV, S_HF, S_HS, S_VV, S_VF, S_VS));
            h++;
            if (h == ht) begin
                h = 0;
                v++;
                if (v == vt) begin
                    v = 0;
                    f++;
                end
            end
        end
    endtask

    function automatic void hand_add(int d, int h, int v, int f, int row, int col,
                                     int crow, int ccol, int bl, int hs, int vs, int bk);
        hand_t t;
        t.d = d; t.h = h; t.v = v; t.f = f;
        t.row = row; t.col = col; t.crow = crow; t.ccol = ccol;
        t.bl = bl; t.hs = hs; t.vs = vs; t.bk = bk; t.hit = 0;
        hand.push_back(t);
    endfunction

    function automatic void cmp_pix(int d, exp_t e, logic [4:0] tr, logic [6:0] tc,
                                    logic [3:0] cr, logic [2:0] cc,
                                    logic bl, logic hs, logic vs, logic bk);
        string tag;
        tag = (d == 0) ? "F" : "S";
        chk(tag, "txtrow", e.h, e.v, 32'(tr), 32'(e.txtrow));
        chk(tag, "txtcol", e.h, e.v, 32'(tc), 32'(e.txtcol));
        chk(tag, "chrrow", e.h, e.v, 32'(cr), 32'(e.chrrow));
        chk(tag, "chrcol", e.h, e.v, 32'(cc), 32'(e.chrcol));
        chk(tag, "blank",  e.h, e.v, 32'(bl), 32'(e.blank));
        chk(tag, "hsync",  e.h, e.v, 32'(hs), 32'(e.hsync));
        chk(tag, "vsync",  e.h, e.v, 32'(vs), 32'(e.vsync));
        chk(tag, "blink",  e.h, e.v, 32'(bk), 32'(e.blink));
        foreach (hand[i]) begin
            if (hand[i].d == d && hand[i].h == e.h && hand[i].v == e.v && hand[i].f == e.f) begin
                hand[i].hit = 1;
                chk(tag, "hand_txtrow", e.h, e.v, 32'(tr), 32'(hand[i].row));
                chk(tag, "hand_txtcol", e.h, e.v, 32'(tc), 32'(hand[i].col));
                chk(tag, "hand_chrrow", e.h, e.v, 32'(cr), 32'(hand[i].crow));
                chk(tag, "hand_chrcol", e.h, e.v, 32'(cc), 32'(hand[i].ccol));
                chk(tag, "hand_blank",  e.h, e.v, 32'(bl), 32'(hand[i].bl));
                chk(tag, "hand_hsync",  e.h, e.v, 32'(hs), 32'(hand[i].hs));
                chk(tag, "hand_vsync",  e.h, e.v, 32'(vs), 32'(hand[i].vs));
                chk(tag, "hand_blink",  e.h, e.v, 32'(bk), 32'(hand[i].bk));
            end
        end
    endfunction

    function automatic void chk_rst(string tag, logic pc, logic [4:0] tr, logic [6:0] tc,
                                    logic [3:0] cr, logic [2:0] cc,
                                    logic bl, logic hs, logic vs, logic bk);
        chk(tag, "rst_pixclk", 0, 0, 32'(pc), 32'd0);
        chk(tag, "rst_txtrow", 0, 0, 32'(tr), 32'd0);
        chk(tag, "rst_txtcol", 0, 0, 32'(tc), 32'd0);
        chk(tag, "rst_chrrow", 0, 0, 32'(cr), 32'd0);
        chk(tag, "rst_chrcol", 0, 0, 32'(cc), 32'd0);
        chk(tag, "rst_blank",  0, 0, 32'(bl), 32'd0);
        chk(tag, "rst_hsync",  0, 0, 32'(hs), 32'd1);
        chk(tag, "rst_vsync",  0, 0, 32'(vs), 32'd1);
        chk(tag, "rst_blink",  0, 0, 32'(bk), 32'd0);
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q_f.size() : q_s.size();
    endfunction

    task automatic drain(input int d);
        int budget;
        budget = 2 * qsize(d) + 40;
        while (qsize(d) > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (qsize(d) > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_%0d: %0d pixels never presented, expected 0", d, qsize(d));
            if (d == 0) q_f.delete();
            else        q_s.delete();
        end
    endtask

    // Monitors: one pixel is presented per clk where pixclk is high.
    always @(negedge clk) begin
        if (!rst_f && if_f.pixclk && q_f.size() > 0) begin
            cmp_pix(0, q_f.pop_front(), if_f.txtrow, if_f.txtcol, if_f.chrrow, if_f.chrcol,
                    if_f.blank, if_f.hsync, if_f.vsync, if_f.blink);
        end
    end

    always @(negedge clk) begin
        if (!rst_s && if_s.pixclk && q_s.size() > 0) begin
            cmp_pix(1, q_s.pop_front(), if_s.txtrow, if_s.txtcol, if_s.chrrow, if_s.chrcol,
                    if_s.blank, if_s.hsync, if_s.vsync, if_s.blink);
        end
    end

    initial begin : stim_full
        hand_add(0,   0, 0, 0,  0,  0, 0, 0,  0, 1, 1, 0);
        hand_add(0, 639, 0, 0,  0, 79, 0, 7,  0, 1, 1, 0);
        hand_add(0, 640, 0, 0,  0,  0, 0, 0,  1, 1, 1, 0);
        hand_add(0, 647, 0, 0,  0,  0, 0, 0,  1, 1, 1, 0);
        hand_add(0, 655, 0, 0,  0,  0, 0, 0,  1, 1, 1, 0);
        hand_add(0, 656, 0, 0,  0,  0, 0, 0,  1, 0, 1, 0);
        hand_add(0, 751, 0, 0,  0,  0, 0, 0,  1, 0, 1, 0);
        hand_add(0, 752, 0, 0,  0,  0, 0, 0,  1, 1, 1, 0);
        hand_add(0, 799, 0, 0,  0,  0, 0, 0,  1, 1, 1, 0);
        hand_add(0,   0, 1, 0,  0,  0, 1, 0,  0, 1, 1, 0);
        hand_add(0, 300, 1, 0,  0, 37, 1, 4,  0, 1, 1, 0);
        push_seg(0, 800 + 301);
        repeat (3) @(posedge clk);
        #1 rst_f = 1'b0;
        @(negedge clk);
        chk_rst("F_release", if_f.pixclk, if_f.txtrow, if_f.txtcol, if_f.chrrow, if_f.chrcol,
                if_f.blank, if_f.hsync, if_f.vsync, if_f.blink);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("F", "pixclk_seq", i, 0, 32'(if_f.pixclk), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        drain(0);
        #1 rst_f = 1'b1;
        @(posedge clk);
        #1;
        push_seg(0, 810);
        rst_f = 1'b0;
        @(negedge clk);
        chk_rst("F_midframe", if_f.pixclk, if_f.txtrow, if_f.txtcol, if_f.chrrow, if_f.chrcol,
                if_f.blank, if_f.hsync, if_f.vsync, if_f.blink);
        drain(0);
        done_f = 1;
    end

    initial begin : stim_small
        hand_add(1, 15, 31,  0, 1, 1, 15, 7, 0, 1, 1, 0);
        hand_add(1, 16, 31,  0, 0, 0,  0, 0, 1, 1, 1, 0);
        hand_add(1, 17,  0,  0, 0, 0,  0, 0, 1, 1, 1, 0);
        hand_add(1, 18,  0,  0, 0, 0,  0, 0, 1, 0, 1, 0);
        hand_add(1, 20,  0,  0, 0, 0,  0, 0, 1, 0, 1, 0);
        hand_add(1, 21,  0,  0, 0, 0,  0, 0, 1, 1, 1, 0);
        hand_add(1,  0, 33,  0, 0, 0,  0, 0, 1, 1, 1, 0);
        hand_add(1,  0, 34,  0, 0, 0,  0, 0, 1, 1, 0, 0);
        hand_add(1, 23, 35,  0, 0, 0,  0, 0, 1, 1, 0, 0);
        hand_add(1,  0, 36,  0, 0, 0,  0, 0, 1, 1, 1, 0);
        hand_add(1, 23, 37,  0, 0, 0,  0, 0, 1, 1, 1, 0);
        hand_add(1,  0,  0,  1, 0, 0,  0, 0, 0, 1, 1, 0);
        hand_add(1,  0,  0, 15, 0, 0,  0, 0, 0, 1, 1, 0);
        hand_add(1,  0,  0, 16, 0, 0,  0, 0, 0, 1, 1, BK);
        hand_add(1,  8, 17, 16, 1, 1,  1, 0, 0, 1, 1, BK);
        hand_add(1,  5,  3, 31, 0, 0,  3, 5, 0, 1, 1, BK);
        hand_add(1,  0,  0, 32, 0, 0,  0, 0, 0, 1, 1, 0);
        push_seg(1, 33 * 24 * 38);
        repeat (3) @(posedge clk);
        #1 rst_s = 1'b0;
        @(negedge clk);
        chk_rst("S_release", if_s.pixclk, if_s.txtrow, if_s.txtcol, if_s.chrrow, if_s.chrcol,
                if_s.blank, if_s.hsync, if_s.vsync, if_s.blink);
        drain(1);
        for (int k = 0; k < 2; k++) begin
            #1 rst_s = 1'b1;
            @(posedge clk);
            #1;
            push_seg(1, (k == 0) ? (24 * 5 + 10) : 30);
            rst_s = 1'b0;
            @(negedge clk);
            chk_rst("S_midframe", if_s.pixclk, if_s.txtrow, if_s.txtcol, if_s.chrrow,
                    if_s.chrcol, if_s.blank, if_s.hsync, if_s.vsync, if_s.blink);
            drain(1);
        end
        done_s = 1;
    end

    initial begin : finish_ctl
        wait (done_f && done_s);
        foreach (hand[i]) begin
            chk(hand[i].d == 0 ? "F" : "S", "hand_vector_reached", hand[i].h, hand[i].v,
                32'(hand[i].hit), 32'd1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #(95000 * 20);
        n_err++;
        $display("FAIL watchdog: run still active at cycle limit, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
